// File: rtl/alu_input_sequencer.sv
// Sequences operand A, operand B and opcode entry for the board ALU from shared switches and buttons.
// Optional per-button debounce is enabled with the BTN_DEBOUNCE_EN macro.
module alu_input_sequencer #(
   parameter int unsigned DATA_SIZE       = 8,
   parameter int unsigned OP_SIZE         = 6,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_SIZE-1:0] i_switches,
   input  logic                 i_btn_a,
   input  logic                 i_btn_b,
   input  logic                 i_btn_op,
   input  logic [DATA_SIZE-1:0] i_alu_result,
   output logic [DATA_SIZE-1:0] o_alu_a,
   output logic [DATA_SIZE-1:0] o_alu_b,
   output logic [OP_SIZE-1:0]   o_alu_op,
   output logic [DATA_SIZE-1:0] o_result,
   output logic                 o_valid,
   output logic [2:0]           o_state
);

   localparam int unsigned NUM_BTN = 3;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   // Button index 0 = A, 1 = B, 2 = OP
   logic [NUM_BTN-1:0] w_btn_raw;
   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] w_level;
   logic [NUM_BTN-1:0] r_level_q;
   logic [NUM_BTN-1:0] w_pulse;

   assign w_btn_raw = {i_btn_op, i_btn_b, i_btn_a};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef BTN_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [NUM_BTN-1:0] r_db_level;
   logic [CNT_W-1:0]   r_db_cnt [NUM_BTN];

   // Level follows the synchroniser only after DEBOUNCE_CYCLES consecutive differing cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_db_level <= '0;
         for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (r_sync2[i] == r_db_level[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_db_level[i] <= r_sync2[i];
               r_db_cnt[i]   <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign w_level = r_db_level;
`else
   assign w_level = r_sync2;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_level_q <= '0;
      else          r_level_q <= w_level;
   end

   assign w_pulse = w_level & ~r_level_q;

   state_t                r_state, w_state_nxt;
   logic [DATA_SIZE-1:0]  r_alu_a, w_alu_a_nxt;
   logic [DATA_SIZE-1:0]  r_alu_b, w_alu_b_nxt;
   logic [OP_SIZE-1:0]    r_alu_op, w_alu_op_nxt;
   logic [DATA_SIZE-1:0]  r_result, w_result_nxt;
   logic                  r_valid, w_valid_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= WAIT_A;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_alu_a  <= w_alu_a_nxt;
         r_alu_b  <= w_alu_b_nxt;
         r_alu_op <= w_alu_op_nxt;
         r_result <= w_result_nxt;
         r_valid  <= w_valid_nxt;
      end
   end

   // Only the pulse the current state expects acts; all others are dropped
   always_comb begin
      w_state_nxt  = r_state;
      w_alu_a_nxt  = r_alu_a;
      w_alu_b_nxt  = r_alu_b;
      w_alu_op_nxt = r_alu_op;
      w_result_nxt = r_result;
      w_valid_nxt  = r_valid;
      case (r_state)
         WAIT_A: begin
            if (w_pulse[0]) begin
               w_alu_a_nxt = i_switches;
               w_state_nxt = WAIT_B;
            end
         end
         WAIT_B: begin
            if (w_pulse[1]) begin
               w_alu_b_nxt = i_switches;
               w_state_nxt = WAIT_OP;
            end
         end
         WAIT_OP: begin
            if (w_pulse[2]) begin
               w_alu_op_nxt = i_switches[OP_SIZE-1:0];
               w_state_nxt  = EXEC;
            end
         end
         EXEC: begin
            w_result_nxt = i_alu_result;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = SHOW;
         end
         SHOW: begin
            if (w_pulse[0]) begin
               w_alu_a_nxt = i_switches;
               w_valid_nxt = 1'b0;
               w_state_nxt = WAIT_B;
            end
         end
         default: w_state_nxt = WAIT_A;
      endcase
   end

   assign o_alu_a  = r_alu_a;
   assign o_alu_b  = r_alu_b;
   assign o_alu_op = r_alu_op;
   assign o_result = r_result;
   assign o_valid  = r_valid;
   assign o_state  = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with a small ALU model on the result input.
// Define BTN_DEBOUNCE_EN to also exercise the bounce scenario (DEBOUNCE_CYCLES=4).
module tb_alu_input_sequencer;

   localparam int unsigned DB = 4;
`ifdef BTN_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] switches;
   logic       btn_a, btn_b, btn_op;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, result;
   logic [5:0] alu_op;
   logic       valid;
   logic [2:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   alu_input_sequencer #(
      .DATA_SIZE(8), .OP_SIZE(6), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_switches(switches),
      .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
      .i_alu_result(alu_result),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
      .o_result(result), .o_valid(valid), .o_state(state)
   );

   always #5 clk = ~clk;

   // Stand-in for the board ALU: ADD and SUB only
   always_comb begin
      case (alu_op)
         6'b100000: alu_result = alu_a + alu_b;
         6'b100010: alu_result = alu_a - alu_b;
         default:   alu_result = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Leaves buttons held; returns just after the FSM acted on the pulse
   task automatic press(input logic [2:0] btns, input logic [7:0] sw);
      switches = sw;
      {btn_op, btn_b, btn_a} = btns;
      step(LAT);
   endtask

   task automatic release_btns();
      {btn_op, btn_b, btn_a} = 3'b000;
      step(LAT + 2);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"},  32'(state),  32'd0);
      check({tag, "_a"},      32'(alu_a),  32'h00);
      check({tag, "_b"},      32'(alu_b),  32'h00);
      check({tag, "_op"},     32'(alu_op), 32'h00);
      check({tag, "_result"}, 32'(result), 32'h00);
      check({tag, "_valid"},  32'(valid),  32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      switches = 8'hFF;
      {btn_op, btn_b, btn_a} = 3'b111;
      @(negedge clk);
      step(3);
      check_zero("rst_hold");
      {btn_op, btn_b, btn_a} = 3'b000;
      step(LAT + 2);
      rst_n = 1'b1;
      step(2);
      check_zero("rst_rel");

      // Out-of-order presses in WAIT_A
      press(3'b010, 8'h77);
      check("ooo_b_state", 32'(state), 32'd0);
      check("ooo_b_reg",   32'(alu_b), 32'h00);
      release_btns();
      press(3'b100, 8'h3F);
      check("ooo_op_state", 32'(state),  32'd0);
      check("ooo_op_reg",   32'(alu_op), 32'h00);
      release_btns();

      // Full entry: 5 + 3
      press(3'b001, 8'h05);
      check("add_a_state", 32'(state), 32'd1);
      check("add_a_reg",   32'(alu_a), 32'h05);
      release_btns();
      press(3'b010, 8'h03);
      check("add_b_state", 32'(state), 32'd2);
      check("add_b_reg",   32'(alu_b), 32'h03);
      release_btns();
      press(3'b100, 8'h20);
      check("add_exec_state", 32'(state),  32'd3);
      check("add_exec_valid", 32'(valid),  32'd0);
      check("add_op_reg",     32'(alu_op), 32'h20);
      step(1);
      check("add_show_state", 32'(state),  32'd4);
      check("add_valid",      32'(valid),  32'd1);
      check("add_result",     32'(result), 32'h08);
      step(5);
      check("add_hold_state", 32'(state),  32'd4);
      release_btns();

      // B and OP ignored in SHOW
      press(3'b110, 8'h99);
      check("show_ign_state", 32'(state),  32'd4);
      check("show_ign_b",     32'(alu_b),  32'h03);
      check("show_ign_op",    32'(alu_op), 32'h20);
      check("show_ign_valid", 32'(valid),  32'd1);
      release_btns();

      // New entry from SHOW: 10 - 4
      press(3'b001, 8'h0A);
      check("sub_a_state",  32'(state),  32'd1);
      check("sub_a_valid",  32'(valid),  32'd0);
      check("sub_a_result", 32'(result), 32'h08);
      check("sub_a_reg",    32'(alu_a),  32'h0A);
      release_btns();
      press(3'b011, 8'h04);
      check("simul_state", 32'(state), 32'd2);
      check("simul_b",     32'(alu_b), 32'h04);
      check("simul_a",     32'(alu_a), 32'h0A);
      release_btns();
      press(3'b100, 8'h22);
      step(1);
      check("sub_state",  32'(state),  32'd4);
      check("sub_valid",  32'(valid),  32'd1);
      check("sub_result", 32'(result), 32'h06);
      release_btns();

`ifdef BTN_DEBOUNCE_EN
      // Bounce on A for 20 cycles, then stable high
      switches = 8'h55;
      for (int k = 0; k < 5; k++) begin
         btn_a = 1'b1; step(2);
         btn_a = 1'b0; step(2);
      end
      check("bounce_state", 32'(state), 32'd4);
      check("bounce_a",     32'(alu_a), 32'h0A);
      btn_a = 1'b1;
      step(LAT - 1);
      check("bounce_early", 32'(state), 32'd4);
      step(1);
      check("bounce_state1", 32'(state), 32'd1);
      check("bounce_a_reg",  32'(alu_a), 32'h55);
      switches = 8'h99;
      step(100);
      check("held_state", 32'(state), 32'd1);
      check("held_a",     32'(alu_a), 32'h55);
      release_btns();
`else
      press(3'b001, 8'h55);
      check("a2_state", 32'(state), 32'd1);
      release_btns();
`endif

      // Async reset in WAIT_OP
      press(3'b010, 8'h11);
      check("pre_rst_state", 32'(state), 32'd2);
      check("pre_rst_b",     32'(alu_b), 32'h11);
      release_btns();
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      press(3'b100, 8'h20);
      check("post_rst_op_state", 32'(state),  32'd0);
      check("post_rst_op_reg",   32'(alu_op), 32'h00);
      release_btns();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
